des_iter_ctrl: RTL and testbench
================================

DES_ITER_CTRL -- requirements
Module: des_iter_ctrl

Interface
REQ-001 Parameters: none; DES round count fixed at 16.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 IN_VALID  in  1  TEXT_IN/KEY/MODE valid.
REQ-005 IN_READY  out  1  controller idle, can accept a block.
REQ-006 TEXT_IN  in  64  plaintext (encrypt) or ciphertext (decrypt).
REQ-007 KEY  in  64  DES key incl. parity bits; parity ignored.
REQ-008 MODE  in  1  0 = encrypt, 1 = decrypt.
REQ-009 F_R  out  32  current R half, to external f-function.
REQ-010 F_SUBKEY  out  48  current round subkey, to external f-function.
REQ-011 F_RESULT  in  32  combinational f(F_R, F_SUBKEY), same cycle.
REQ-012 OUT_VALID  out  1  TEXT_OUT holds a finished result.
REQ-013 OUT_READY  in  1  consumer accepts TEXT_OUT.
REQ-014 TEXT_OUT  out  64  FP(R16||L16).
REQ-015 BUSY  out  1  high in RUN and DONE.
REQ-016 ROUND  out  4  index of round executed at next edge, 0..15; 0 outside RUN.

Function
REQ-017 FSM states: IDLE, RUN, DONE; IN_READY = (state==IDLE).
REQ-018 IDLE->RUN on edge with IN_VALID&IN_READY; at that edge: L||R <= IP(TEXT_IN), C||D <= PC1(KEY), mode latched, counter <= 0.
REQ-019 KEY, TEXT_IN and MODE changes after acceptance have no effect on the block in flight.
REQ-020 Each RUN edge: C,D <= shifted C,D; L <= R; R <= L ^ F_RESULT; counter += 1.
REQ-021 F_SUBKEY = PC2 of the shifted C,D (the values being registered that edge); combinational.
REQ-022 Encrypt shifts: rotate left by 1 in rounds 0,1,8,15, by 2 otherwise.
REQ-023 Decrypt shifts: no rotation in round 0; rotate right by 1 in rounds 1,8,15, by 2 otherwise.
REQ-024 After the round-15 edge, state=DONE, OUT_VALID=1; OUT_VALID rises exactly 16 edges after the accept edge.
REQ-025 TEXT_OUT = FP(R||L) (halves swapped); stable while OUT_VALID=1.
REQ-026 DONE->IDLE on OUT_VALID&OUT_READY; the block is not accepted in the same cycle; IN_READY rises the next cycle.
REQ-027 OUT_READY held low: DONE held indefinitely, outputs stable.
REQ-028 IN_VALID while not IN_READY: ignored, no state change.
REQ-029 OUT_READY outside DONE: ignored.

Reset
REQ-030 RST=1 at an edge forces IDLE from any state, including mid-RUN and DONE; the in-flight block is discarded.
REQ-031 Reset values: OUT_VALID=0, BUSY=0, IN_READY=1 (after the edge), ROUND=0, TEXT_OUT=0, L/R/C/D/counter=0.
REQ-032 RST has priority over IN_VALID and OUT_READY in the same cycle.

Configuration
REQ-033 Macro DES_ITER_DECRYPT_EN: when defined, MODE is honoured per REQ-023.
REQ-034 Without DES_ITER_DECRYPT_EN: MODE is ignored, the encrypt schedule is always used, and the right-rotate logic is not compiled; the port remains present.

Structure
REQ-035 Package des_pkg holds the IP, FP, PC1 and PC2 permutation tables, the per-round shift table, the state enum, and width constants (64/56/48/32).
REQ-036 One sub-module, des_key_sched: holds C/D registers, rotation per mode and round, PC2 output; the controller owns the FSM, L/R and the output register.
REQ-037 The f-function is external; the bench pairs the controller with the team's combinational f-function (expansion, S-boxes, P).

Verification
REQ-038 KEY=133457799BBCDFF1, TEXT_IN=0123456789ABCDEF, MODE=0 -> TEXT_OUT=85E813540F0AB405, OUT_VALID 16 edges after accept.
REQ-039 Same KEY, TEXT_IN=85E813540F0AB405, MODE=1 (macro defined) -> TEXT_OUT=0123456789ABCDEF; without macro -> 85E813540F0AB405 re-encrypted, not plaintext.
REQ-040 KEY=0, TEXT_IN=0, MODE=0 -> TEXT_OUT=8CA64DE9C1B123A7.
REQ-041 Hold OUT_READY=0 for 20 cycles in DONE, toggle KEY/TEXT_IN meanwhile -> TEXT_OUT unchanged, IN_READY=0, then one-cycle OUT_READY -> IDLE next cycle.
REQ-042 Assert RST at ROUND=7 -> next cycle IN_READY=1, OUT_VALID=0; then a fresh REQ-038 block gives 85E813540F0AB405.
REQ-043 IN_VALID held high continuously with OUT_READY=1 -> one block per 18 cycles, IN_READY never high while BUSY.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants for the iterative controller: permutation tables, the
// per-round key rotation table, the controller state enum and rotation helpers.
package des_pkg;

    localparam int BLOCK_W  = 64;
    localparam int CD_W2    = 56;
    localparam int SUBKEY_W = 48;
    localparam int HALF_W   = 32;
    localparam int CD_W     = 28;
    localparam int ROUNDS   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned IP_TAB [BLOCK_W] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int unsigned FP_TAB [BLOCK_W] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };

    // Parity bits (8, 16, ..., 64) never appear, so they drop out here.
    localparam int unsigned PC1_TAB [CD_W2] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    localparam int unsigned SHIFT_TAB [ROUNDS] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    function automatic logic [BLOCK_W-1:0] ip_perm(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < BLOCK_W; i++) y[6'(BLOCK_W-1-i)] = x[6'(BLOCK_W-IP_TAB[i])];
        return y;
    endfunction

    function automatic logic [BLOCK_W-1:0] fp_perm(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int i = 0; i < BLOCK_W; i++) y[6'(BLOCK_W-1-i)] = x[6'(BLOCK_W-FP_TAB[i])];
        return y;
    endfunction

    function automatic logic [CD_W2-1:0] pc1_perm(input logic [BLOCK_W-1:0] x);
        logic [CD_W2-1:0] y;
        y = '0;
        for (int i = 0; i < CD_W2; i++) y[6'(CD_W2-1-i)] = x[6'(BLOCK_W-PC1_TAB[i])];
        return y;
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2_perm(input logic [CD_W2-1:0] x);
        logic [SUBKEY_W-1:0] y;
        y = '0;
        for (int i = 0; i < SUBKEY_W; i++) y[6'(SUBKEY_W-1-i)] = x[6'(CD_W2-PC2_TAB[i])];
        return y;
    endfunction

    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic one);
        return one ? {x[CD_W-2:0], x[CD_W-1]} : {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
    endfunction

`ifdef DES_ITER_DECRYPT_EN
    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic one);
        return one ? {x[0], x[CD_W-1:1]} : {x[1:0], x[CD_W-1:2]};
    endfunction
`endif

endpackage

// File: rtl/des_key_sched.sv
// DES key schedule: C/D registers, per-round rotation and PC2 subkey output.
// Decrypt (right-rotate) schedule only exists when DES_ITER_DECRYPT_EN is defined.
module des_key_sched
    import des_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [BLOCK_W-1:0]  key_i,
    input  logic                mode_i,
    input  logic [3:0]          round_i,
    output logic [SUBKEY_W-1:0] subkey_o
);

    logic [CD_W-1:0] c_q, c_d;
    logic [CD_W-1:0] d_q, d_d;
    logic            shift_one;

    assign shift_one = (SHIFT_TAB[round_i] == 1);

    // NOTE: every always_comb output gets a value on every path (default first), so no latch is inferred.
`ifdef DES_ITER_DECRYPT_EN
    logic mode_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= 1'b0;
        end else if (load_i) begin
            mode_q <= mode_i;
        end
    end

    // Decrypt walks the encrypt schedule backwards: K16 first (C0/D0 unrotated).
    always_comb begin
        c_d = rotl28(c_q, shift_one);
        d_d = rotl28(d_q, shift_one);
        if (mode_q) begin
            if (round_i == 4'd0) begin
                c_d = c_q;
                d_d = d_q;
            end else begin
                c_d = rotr28(c_q, shift_one);
                d_d = rotr28(d_q, shift_one);
            end
        end
    end
`else
    logic mode_unused;
    assign mode_unused = mode_i;

    always_comb begin
        c_d = rotl28(c_q, shift_one);
        d_d = rotl28(d_q, shift_one);
    end
`endif

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_q <= '0;
            d_q <= '0;
        end else if (load_i) begin
            {c_q, d_q} <= pc1_perm(key_i);
        end else if (step_i) begin
            c_q <= c_d;
            d_q <= d_d;
        end
    end

    assign subkey_o = pc2_perm({c_d, d_d});

endmodule

// File: rtl/des_iter_ctrl.sv
// Iterative DES round controller (one round per clock, external f-function).
// Define DES_ITER_DECRYPT_EN to honour MODE=1 (decrypt); otherwise always encrypts.
module des_iter_ctrl
    import des_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [BLOCK_W-1:0]  TEXT_IN,
    input  logic [BLOCK_W-1:0]  KEY,
    input  logic                MODE,
    output logic [HALF_W-1:0]   F_R,
    output logic [SUBKEY_W-1:0] F_SUBKEY,
    input  logic [HALF_W-1:0]   F_RESULT,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [BLOCK_W-1:0]  TEXT_OUT,
    output logic                BUSY,
    output logic [3:0]          ROUND
);

    state_e             state_q;
    logic [HALF_W-1:0]  l_q, r_q, r_d;
    logic [3:0]         cnt_q;
    logic [BLOCK_W-1:0] text_out_q;
    logic               in_ready_q, out_valid_q, busy_q;
    logic               load, step;

    assign load = (state_q == ST_IDLE) && IN_VALID;
    assign step = (state_q == ST_RUN);
    assign r_d  = l_q ^ F_RESULT;

    des_key_sched u_key_sched (
        .clk_i    (CLK),
        .rst_i    (RST),
        .load_i   (load),
        .step_i   (step),
        .key_i    (KEY),
        .mode_i   (MODE),
        .round_i  (cnt_q),
        .subkey_o (F_SUBKEY)
    );

    // The counter wraps to 0 on the round-15 edge, so ROUND reads 0 outside RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            l_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            text_out_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        state_q    <= ST_RUN;
                        {l_q, r_q} <= ip_perm(TEXT_IN);
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    l_q   <= r_q;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(ROUNDS - 1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        text_out_q  <= fp_perm({r_d, r_q});
                    end
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign TEXT_OUT  = text_out_q;
    assign ROUND     = cnt_q;
    assign F_R       = r_q;

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Bench for des_iter_ctrl: supplies the combinational f-function and compares
// results against a whole-block DES reference model computed in the bench.
module tb_des_iter_ctrl;
    import des_pkg::*;

`ifdef DES_ITER_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    logic        CLK = 1'b0;
    logic        RST, IN_VALID, IN_READY, MODE, OUT_VALID, OUT_READY, BUSY;
    logic [63:0] TEXT_IN, KEY, TEXT_OUT;
    logic [31:0] F_R, F_RESULT;
    logic [47:0] F_SUBKEY;
    logic [3:0]  ROUND;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    des_iter_ctrl dut (
        .CLK (CLK), .RST (RST), .IN_VALID (IN_VALID), .IN_READY (IN_READY),
        .TEXT_IN (TEXT_IN), .KEY (KEY), .MODE (MODE), .F_R (F_R), .F_SUBKEY (F_SUBKEY),
        .F_RESULT (F_RESULT), .OUT_VALID (OUT_VALID), .OUT_READY (OUT_READY),
        .TEXT_OUT (TEXT_OUT), .BUSY (BUSY), .ROUND (ROUND)
    );

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, y;
        logic [5:0]  six;
        e = '0;
        s = '0;
        y = '0;
        for (int i = 0; i < 48; i++) e[6'(47-i)] = r[5'(32-E_TAB[i])];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = e[(7-b)*6 +: 6];
            s[(7-b)*4 +: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
        end
        for (int i = 0; i < 32; i++) y[5'(31-i)] = s[5'(32-P_TAB[i])];
        return y;
    endfunction

    always_comb F_RESULT = f_func(F_R, F_SUBKEY);

    // Whole-block DES: all 16 subkeys first, decryption just uses them in reverse.
    function automatic logic [63:0] ref_des(input logic [63:0] key, input logic [63:0] blk,
                                            input logic mode);
        logic [47:0] sk [16];
        logic [27:0] c, d;
        logic [31:0] l, r, tmp;
        logic        dec;
        int          n;
        dec = mode && DEC_EN;
        {c, d} = pc1_perm(key);
        for (int i = 0; i < 16; i++) begin
            n = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
            for (int j = 0; j < n; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            sk[i] = pc2_perm({c, d});
        end
        {l, r} = ip_perm(blk);
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r   = l ^ f_func(r, dec ? sk[15-i] : sk[i]);
            l   = tmp;
        end
        return fp_perm({r, l});
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic scramble_inputs();
        KEY     = {$urandom(), $urandom()};
        TEXT_IN = {$urandom(), $urandom()};
        MODE    = 1'($urandom_range(0, 1));
    endtask

    // One block end to end: accept, 16 rounds, optional OUT_READY stall, release.
    task automatic do_block(input logic [63:0] key, input logic [63:0] text, input logic mode,
                            input logic [63:0] exp, input int hold, input string tag);
        int          lat;
        bit          ok;
        logic [63:0] held;
        @(negedge CLK);
        check({tag, ".in_ready"}, 64'(IN_READY), 64'd1);
        IN_VALID = 1'b1;
        KEY = key;
        TEXT_IN = text;
        MODE = mode;
        OUT_READY = 1'($urandom_range(0, 1));
        @(negedge CLK);
        lat = 0;
        ok  = 1'b1;
        while (!OUT_VALID && lat < 40) begin
            if (ROUND !== 4'(lat) || BUSY !== 1'b1 || IN_READY !== 1'b0) ok = 1'b0;
            scramble_inputs();
            IN_VALID  = 1'($urandom_range(0, 1));
            OUT_READY = 1'($urandom_range(0, 1));
            @(negedge CLK);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd16);
        check({tag, ".run_flags"}, 64'(ok), 64'd1);
        check({tag, ".text_out"}, TEXT_OUT, exp);
        held = TEXT_OUT;
        ok   = 1'b1;
        for (int i = 0; i < hold; i++) begin
            OUT_READY = 1'b0;
            scramble_inputs();
            IN_VALID = 1'($urandom_range(0, 1));
            @(negedge CLK);
            if (TEXT_OUT !== held || OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || ROUND !== 4'd0) ok = 1'b0;
        end
        check({tag, ".hold"}, 64'(ok), 64'd1);
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;
        check({tag, ".release"}, 64'({IN_READY, OUT_VALID, BUSY}), 64'b100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] k, t;
        logic        m;
        int          w, last, n_acc;
        bit          ok;
        logic [63:0] exp_q [$];

        RST = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        KEY = '0;
        TEXT_IN = '0;
        MODE = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst.in_ready", 64'(IN_READY), 64'd1);
        check("rst.out_valid", 64'(OUT_VALID), 64'd0);
        check("rst.busy", 64'(BUSY), 64'd0);
        check("rst.round", 64'(ROUND), 64'd0);
        check("rst.text_out", TEXT_OUT, 64'd0);
        RST = 1'b0;

        do_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 20, "kat_enc");
        do_block(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1,
                 DEC_EN ? 64'h0123456789ABCDEF : ref_des(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0),
                 2, "kat_dec");
        do_block(64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7, 0, "kat_zero");

        // Reset in the middle of RUN, with IN_VALID/OUT_READY also high.
        @(negedge CLK);
        IN_VALID = 1'b1;
        scramble_inputs();
        @(negedge CLK);
        IN_VALID = 1'b0;
        w = 0;
        while (ROUND != 4'd7 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        check("midrst.round7", 64'(ROUND), 64'd7);
        RST = 1'b1;
        IN_VALID = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        check("midrst.state", 64'({IN_READY, OUT_VALID, BUSY, ROUND}), 64'b100_0000);
        check("midrst.text_out", TEXT_OUT, 64'd0);
        do_block(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 0, "post_rst");

        // Reset while holding a finished result.
        @(negedge CLK);
        IN_VALID = 1'b1;
        scramble_inputs();
        @(negedge CLK);
        IN_VALID = 1'b0;
        w = 0;
        while (!OUT_VALID && w < 40) begin
            @(negedge CLK);
            w++;
        end
        check("donerst.reached", 64'(OUT_VALID), 64'd1);
        RST = 1'b1;
        IN_VALID = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        check("donerst.state", 64'({IN_READY, OUT_VALID, BUSY}), 64'b100);
        check("donerst.text_out", TEXT_OUT, 64'd0);

        for (int i = 0; i < 8; i++) begin
            k = {$urandom(), $urandom()};
            t = {$urandom(), $urandom()};
            m = 1'($urandom_range(0, 1));
            do_block(k, t, m, ref_des(k, t, m), $urandom_range(0, 3), "rand");
        end

        // Back-to-back traffic: IN_VALID and OUT_READY held high.
        OUT_READY = 1'b1;
        ok = 1'b1;
        last = -1;
        n_acc = 0;
        for (int cyc = 0; cyc < 240; cyc++) begin
            @(negedge CLK);
            if (IN_READY === 1'b1 && BUSY === 1'b1) ok = 1'b0;
            if (OUT_VALID === 1'b1) begin
                if (exp_q.size() == 0) check("thr.unexpected_out", 64'd1, 64'd0);
                else check("thr.text_out", TEXT_OUT, exp_q.pop_front());
            end
            scramble_inputs();
            IN_VALID = (cyc < 200);
            if (IN_READY === 1'b1 && IN_VALID) begin
                if (last >= 0 && cyc - last != 18) ok = 1'b0;
                last = cyc;
                n_acc++;
                exp_q.push_back(ref_des(KEY, TEXT_IN, MODE));
            end
        end
        check("thr.spacing_and_busy", 64'(ok), 64'd1);
        check("thr.accept_count", 64'(n_acc), 64'd12);
        check("thr.drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
